ram16x8_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for a single-port 16x8 synchronous RAM (en/we/addr/datain, registered dataout, one-cycle read latency, write-first).
- Requesters A and B share the RAM through a req/gnt handshake; the block registers the RAM command and returns read data with a per-requester valid pulse.
- Sits between two client engines and one ram16x8 instance.

---
 rtl/ram16x8_arbiter_pkg.sv | 19 +
 rtl/ram16x8_arbiter_rr_arb2.sv | 35 +++
 rtl/ram16x8_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ram16x8_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram16x8_arbiter_pkg.sv
// rtl/ram16x8_arbiter_pkg.sv - shared constants and types for the ram16x8 arbiter
package ram16x8_arbiter_pkg;

    // Default geometry of the attached ram16x8
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // Requester identifiers, used as bit indices into eligible/grant vectors
    // and as the in-flight read tag value
    localparam int unsigned REQ_A = 0;
    localparam int unsigned REQ_B = 1;

    // Round-robin priority: which requester wins when both are eligible
    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

endpackage

// File: rtl/ram16x8_arbiter_rr_arb2.sv
// rtl/ram16x8_arbiter_rr_arb2.sv - two-way round-robin picker
module ram16x8_arbiter_rr_arb2
    import ram16x8_arbiter_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       pri_state,
    output logic [1:0] grant,
    output logic       pri_next
);

    // Pick at most one requester; the loser of a tie wins the next tie
    always_comb begin
        grant    = 2'b00;
        pri_next = pri_state;
        case (eligible)
            2'b01:   grant[REQ_A] = 1'b1;
            2'b10:   grant[REQ_B] = 1'b1;
            2'b11: begin
                if (pri_state == PRI_A) begin
                    grant[REQ_A] = 1'b1;
                end else begin
                    grant[REQ_B] = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase
        // Priority only moves when something is actually accepted
        if (grant[REQ_A]) begin
            pri_next = PRI_B;
        end else if (grant[REQ_B]) begin
            pri_next = PRI_A;
        end
    end

endmodule

// File: rtl/ram16x8_arbiter.sv
// rtl/ram16x8_arbiter.sv - round-robin sequencer sharing one ram16x8 between two requesters
module ram16x8_arbiter
    import ram16x8_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Priority FSM state
    pri_e              pri_q;
    pri_e              pri_d;

    // Registered RAM command
    logic              ram_en_q;
    logic              ram_en_d;
    logic              ram_we_q;
    logic              ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_din_q;
    logic [DATA_W-1:0] ram_din_d;

    // Grant pulses, high in the cycle the command sits on the RAM bus
    logic              a_gnt_q;
    logic              a_gnt_d;
    logic              b_gnt_q;
    logic              b_gnt_d;

    // Read tag for the command currently on the RAM bus
    logic              rd1_vld_q;
    logic              rd1_vld_d;
    logic              rd1_id_q;
    logic              rd1_id_d;

    // Read tag for the data currently on ram_dout
    logic              a_rvalid_q;
    logic              a_rvalid_d;
    logic              b_rvalid_q;
    logic              b_rvalid_d;

    // Last delivered read data, shown while rvalid is low
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q;
    logic [DATA_W-1:0] b_rdata_d;

    logic [1:0]        eligible;
    logic [1:0]        pick;
    logic              pri_next;

    // A requester in its grant cycle is masked so a held req is not taken twice
    assign eligible[REQ_A] = a_req & ~a_gnt_q;
    assign eligible[REQ_B] = b_req & ~b_gnt_q;

    ram16x8_arbiter_rr_arb2 u_rr_arb2 (
        .eligible  (eligible),
        .pri_state (pri_q),
        .grant     (pick),
        .pri_next  (pri_next)
    );

    // Priority FSM next state comes straight from the picker
    always_comb begin
        pri_d = pri_q;
        pri_d = pri_e'(pri_next);
    end

    // Priority FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= PRI_A;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Build the next RAM command and read tags from the winning requester
    always_comb begin
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rd1_vld_d  = 1'b0;
        rd1_id_d   = rd1_id_q;
        a_gnt_d    = pick[REQ_A];
        b_gnt_d    = pick[REQ_B];
        if (pick[REQ_A]) begin
            ram_en_d   = 1'b1;
            ram_we_d   = a_we;
            ram_addr_d = a_addr;
            ram_din_d  = a_wdata;
            rd1_vld_d  = ~a_we;
            rd1_id_d   = 1'(REQ_A);
        end else if (pick[REQ_B]) begin
            ram_en_d   = 1'b1;
            ram_we_d   = b_we;
            ram_addr_d = b_addr;
            ram_din_d  = b_wdata;
            rd1_vld_d  = ~b_we;
            rd1_id_d   = 1'(REQ_B);
        end
    end

    // Advance the read tag one stage to line up with registered ram_dout,
    // and latch delivered data so rdata holds between pulses
    always_comb begin
        a_rvalid_d = rd1_vld_q & (rd1_id_q == 1'(REQ_A));
        b_rvalid_d = rd1_vld_q & (rd1_id_q == 1'(REQ_B));
        a_rdata_d  = a_rvalid_q ? ram_dout : a_rdata_q;
        b_rdata_d  = b_rvalid_q ? ram_dout : b_rdata_q;
    end

    // Command, grant and read-tag registers; reset drops any in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            rd1_vld_q  <= 1'b0;
            rd1_id_q   <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            rd1_vld_q  <= rd1_vld_d;
            rd1_id_q   <= rd1_id_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    // Read data comes straight off the RAM in the valid cycle
    assign a_rdata  = a_rvalid_q ? ram_dout : a_rdata_q;
    assign b_rdata  = b_rvalid_q ? ram_dout : b_rdata_q;

endmodule

// File: tb/tb_ram16x8_arbiter.sv
// tb/tb_ram16x8_arbiter.sv - scoreboard bench for ram16x8_arbiter with a behavioural ram16x8
module tb_ram16x8_arbiter;

    typedef struct {
        int cyc;
        int data;
    } rv_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [3:0] a_addr = 4'd0;
    logic [7:0] a_wdata = 8'd0;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [3:0] b_addr = 4'd0;
    logic [7:0] b_wdata = 8'd0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_en, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = 8'd0;
    logic [7:0] mem [16];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_base;
    int t;

    int  exp_a_gnt[$];
    int  exp_b_gnt[$];
    rv_t exp_a_rv[$];
    rv_t exp_b_rv[$];
    rv_t ea, eb;

    ram16x8_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ram16x8: registered output, write-first
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                ram_dout      <= ram_din;
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pulses"}, int'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 0);
        chk({tag, "_ram_en_we"}, int'({ram_en, ram_we}), 0);
        chk({tag, "_ram_addr"}, int'(ram_addr), 0);
        chk({tag, "_ram_din"}, int'(ram_din), 0);
        chk({tag, "_a_rdata"}, int'(a_rdata), 0);
        chk({tag, "_b_rdata"}, int'(b_rdata), 0);
    endtask

    // Monitor: every grant / rvalid pulse pops its expectation
    always @(negedge clk) begin
        if (ram_en) en_cnt++;
        if (a_gnt) begin
            if (exp_a_gnt.size() == 0) unexpected("a_gnt");
            else chk("a_gnt_cycle", cyc, exp_a_gnt.pop_front());
        end
        if (b_gnt) begin
            if (exp_b_gnt.size() == 0) unexpected("b_gnt");
            else chk("b_gnt_cycle", cyc, exp_b_gnt.pop_front());
        end
        if (a_rvalid) begin
            if (exp_a_rv.size() == 0) unexpected("a_rvalid");
            else begin
                ea = exp_a_rv.pop_front();
                chk("a_rvalid_cycle", cyc, ea.cyc);
                chk("a_rdata", int'(a_rdata), ea.data);
            end
        end
        if (b_rvalid) begin
            if (exp_b_rv.size() == 0) unexpected("b_rvalid");
            else begin
                eb = exp_b_rv.pop_front();
                chk("b_rvalid_cycle", cyc, eb.cyc);
                chk("b_rdata", int'(b_rdata), eb.data);
            end
        end
    end

    initial begin
        #2;
        chk_reset_outputs("por");
        step(); step();
        rst_n = 1'b1;
        step();

        // A writes addr 3 = 0x5A, then reads it back
        en_base = en_cnt;
        step(); drive_a(1'b1, 1'b1, 4'd3, 8'h5A); t = cyc;
        exp_a_gnt.push_back(t + 1);
        step();
        step(); drive_a(1'b1, 1'b0, 4'd3, 8'h00);
        exp_a_gnt.push_back(t + 3);
        exp_a_rv.push_back('{cyc: t + 4, data: 'h5A});
        step();
        step(); drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        step(); step();
        chk("p1_ram_en_cycles", en_cnt - en_base, 2);

        // Preload: simultaneous writes, PRI_B after A -> B first; B holds req over its gnt
        step(); drive_a(1'b1, 1'b1, 4'd1, 8'h11); drive_b(1'b1, 1'b1, 4'd2, 8'h22); t = cyc;
        exp_b_gnt.push_back(t + 1);
        exp_a_gnt.push_back(t + 2);
        step();
        step(); drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        step(); drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        step(); step();

        // Continuous reads from both: strict alternation, RAM busy every cycle
        step(); drive_a(1'b1, 1'b0, 4'd1, 8'h00); drive_b(1'b1, 1'b0, 4'd2, 8'h00); t = cyc;
        en_base = en_cnt;
        for (int k = 0; k < 3; k++) begin
            exp_b_gnt.push_back(t + 1 + 2 * k);
            exp_a_gnt.push_back(t + 2 + 2 * k);
            exp_b_rv.push_back('{cyc: t + 2 + 2 * k, data: 'h22});
            exp_a_rv.push_back('{cyc: t + 3 + 2 * k, data: 'h11});
        end
        for (int k = 0; k < 6; k++) step();
        drive_a(1'b0, 1'b0, 4'd0, 8'h00); drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        step(); step(); step();
        chk("p3_ram_en_cycles", en_cnt - en_base, 6);

        // B alone, then a tie: A must win after B's accept
        step(); drive_b(1'b1, 1'b0, 4'd2, 8'h00); t = cyc;
        exp_b_gnt.push_back(t + 1);
        exp_b_rv.push_back('{cyc: t + 2, data: 'h22});
        step();
        step(); drive_a(1'b1, 1'b0, 4'd1, 8'h00);
        exp_a_gnt.push_back(t + 3);
        exp_a_rv.push_back('{cyc: t + 4, data: 'h11});
        exp_b_gnt.push_back(t + 4);
        exp_b_rv.push_back('{cyc: t + 5, data: 'h22});
        step();
        step(); drive_a(1'b0, 1'b0, 4'd0, 8'h00); drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        step(); step(); step();

        // B writes addr 7 = 0xC3, A reads addr 7 granted right after
        step(); drive_b(1'b1, 1'b1, 4'd7, 8'hC3); t = cyc;
        exp_b_gnt.push_back(t + 1);
        step(); drive_a(1'b1, 1'b0, 4'd7, 8'h00);
        exp_a_gnt.push_back(t + 2);
        exp_a_rv.push_back('{cyc: t + 3, data: 'hC3});
        step(); drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        step(); drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        step(); step();

        // Reset in the middle of an A read: no rvalid afterwards, first tie to A
        step(); drive_a(1'b1, 1'b0, 4'd3, 8'h00); t = cyc;
        exp_a_gnt.push_back(t + 1);
        step();
        #6;
        rst_n = 1'b0;
        drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        chk_reset_outputs("midrst");
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        step(); drive_a(1'b1, 1'b0, 4'd3, 8'h00); drive_b(1'b1, 1'b0, 4'd7, 8'h00); t = cyc;
        exp_a_gnt.push_back(t + 1);
        exp_a_rv.push_back('{cyc: t + 2, data: 'h5A});
        exp_b_gnt.push_back(t + 2);
        exp_b_rv.push_back('{cyc: t + 3, data: 'hC3});
        step();
        step(); drive_a(1'b0, 1'b0, 4'd0, 8'h00); drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        step(); step(); step();

        // B loses a tie and withdraws before it becomes eligible: no B access
        step(); drive_a(1'b1, 1'b0, 4'd1, 8'h00); drive_b(1'b1, 1'b0, 4'd2, 8'h00); t = cyc;
        en_base = en_cnt;
        exp_a_gnt.push_back(t + 1);
        exp_a_rv.push_back('{cyc: t + 2, data: 'h11});
        step(); drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        step(); drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        step(); step(); step();
        chk("p7_ram_en_cycles", en_cnt - en_base, 1);

        // rdata holds the last delivered value; everything expected arrived
        chk("a_rdata_hold", int'(a_rdata), 'h11);
        chk("b_rdata_hold", int'(b_rdata), 'hC3);
        chk("a_gnt_left", exp_a_gnt.size(), 0);
        chk("b_gnt_left", exp_b_gnt.size(), 0);
        chk("a_rv_left", exp_a_rv.size(), 0);
        chk("b_rv_left", exp_b_rv.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
